// File: rtl/ddram_wr_buffer.sv
// DDR write buffer: byte-merging staging register, FIFO and registered output.
// Ports: upstream in_* write beat, clr_ovf/overflow/level status, DDRAM_* master.
module ddram_wr_buffer #(
  parameter int DEPTH_LOG2   = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                  CLK_VIDEO,
  input  logic                  reset_n,
  input  logic [28:0]           in_addr,
  input  logic [63:0]           in_din,
  input  logic [7:0]            in_be,
  input  logic                  in_we,
  input  logic                  clr_ovf,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  DDRAM_CLK,
  input  logic                  DDRAM_BUSY,
  output logic [7:0]            DDRAM_BURSTCNT,
  output logic [28:0]           DDRAM_ADDR,
  output logic [63:0]           DDRAM_DIN,
  output logic [7:0]            DDRAM_BE,
  output logic                  DDRAM_WE,
  output logic                  DDRAM_RD
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] FLUSH_N = 8'(FLUSH_CYCLES);
  localparam logic [DEPTH_LOG2:0] FULL_N =
    (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_ONE =
    (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] P_ONE =
    DEPTH_LOG2'(1);

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  beat_t                 mem [DEPTH];
  beat_t                 stg_q, stg_d, mrg;
  beat_t                 out_q, out_d;
  logic                  stg_vld_q, stg_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            idle_q, idle_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;

  logic consume, out_free, pop;
  logic stg_full, merge, flush;
  logic push_req, room, push;

  always_comb begin
    consume  = out_vld_q & ~DDRAM_BUSY;
    out_free = ~out_vld_q | consume;
    pop      = (cnt_q != '0) & out_free;

    stg_full = stg_vld_q & (stg_q.be == 8'hFF);
    merge    = in_we & stg_vld_q & ~stg_full &
               (in_addr == stg_q.addr) &
               ((in_be & stg_q.be) == 8'h00);
    flush    = stg_vld_q & ~in_we &
               (idle_q >= FLUSH_N);
    push_req = stg_vld_q &
               (stg_full | (in_we & ~merge) | flush);
    // occupancy is judged after this cycle's pop
    room     = (cnt_q != FULL_N) | pop;
    push     = push_req & room;

    mrg      = stg_q;
    mrg.be   = stg_q.be | in_be;
    for (int i = 0; i < 8; i++) begin
      if (in_be[i]) begin
        mrg.data[8*i +: 8] = in_din[8*i +: 8];
      end
    end

    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    unique case (1'b1)
      merge: begin
        stg_d = mrg;
      end
      (in_we & ~merge): begin
        stg_vld_d  = 1'b1;
        stg_d.addr = in_addr;
        stg_d.data = in_din;
        stg_d.be   = in_be;
      end
      (~in_we & push_req): begin
        stg_vld_d = 1'b0;
      end
      default: ;
    endcase

    if (in_we | ~stg_vld_q | push_req) begin
      idle_d = 8'd0;
    end else if (idle_q != 8'hFF) begin
      idle_d = idle_q + 8'd1;
    end else begin
      idle_d = idle_q;
    end

    wr_ptr_d = push ? wr_ptr_q + P_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + P_ONE : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + C_ONE;
      2'b01:   cnt_d = cnt_q - C_ONE;
      default: cnt_d = cnt_q;
    endcase

    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (out_free) begin
      out_vld_d = pop;
      if (pop) begin
        out_d = mem[rd_ptr_q];
      end
    end

    // a new drop wins over a same-cycle clear
    if (push_req & ~room) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
    if (!reset_n) begin
      stg_q     <= '0;
      stg_vld_q <= 1'b0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      idle_q    <= 8'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
      idle_q    <= idle_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (push) begin
      mem[wr_ptr_q] <= stg_q;
    end
  end

  assign DDRAM_CLK      = CLK_VIDEO;
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_RD       = 1'b0;
  assign DDRAM_WE       = out_vld_q;
  assign DDRAM_ADDR     = out_q.addr;
  assign DDRAM_DIN      = out_q.data;
  assign DDRAM_BE       = out_q.be;
  assign level          = cnt_q;
  assign overflow       = ovf_q;

endmodule
